// File: rtl/cb_seg_pkg.sv
// Shared constants, FSM state type and K-table step helper for the code block segmenter.
package cb_seg_pkg;
  localparam int          Z_LTE       = 6144;
  localparam int          L_CB        = 24;
  localparam int          K_MIN       = 40;
  localparam logic [23:0] CRC24B_POLY = 24'h800063;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC_C,
    S_CALC_K,
    S_CALC_CM,
    S_EMIT
  } seg_state_e;

  // Spacing between consecutive turbo interleaver sizes starting at k.
  function automatic logic [6:0] k_step(input logic [12:0] k);
    if (k < 13'd512)       return 7'd8;
    else if (k < 13'd1024) return 7'd16;
    else if (k < 13'd2048) return 7'd32;
    else                   return 7'd64;
  endfunction
endpackage

// File: rtl/cb_seg_hs_if.sv
// Size/data/code-block handshake bundle of cb_seg_hs; slave is the segmenter side.
interface cb_seg_hs_if #(
  parameter int SIZE_W = 16,
  parameter int CIDX_W = 4
);
  logic [SIZE_W-1:0] tb_size_in;
  logic              wreq_size;
  logic              size_ready;
  logic              tb_in;
  logic              wreq_data;
  logic              data_ready;
  logic              cb_ready;
  logic              cb_valid;
  logic              cb_data;
  logic              filling;
  logic              crc;
  logic              start;
  logic              stop;
  logic [12:0]       cb_size;
  logic [CIDX_W-1:0] cb_idx;
  logic              seg_err;

  modport master (
    output tb_size_in, wreq_size, tb_in, wreq_data, cb_ready,
    input  size_ready, data_ready, cb_valid, cb_data, filling, crc,
           start, stop, cb_size, cb_idx, seg_err
  );

  modport slave (
    input  tb_size_in, wreq_size, tb_in, wreq_data, cb_ready,
    output size_ready, data_ready, cb_valid, cb_data, filling, crc,
           start, stop, cb_size, cb_idx, seg_err
  );
endinterface

// File: rtl/crc24b_serial.sv
// Bit-serial CRC24B generator with remainder shift-out; only built when CB_SEG_CRC24B_EN is defined.
`ifdef CB_SEG_CRC24B_EN
module crc24b_serial
  import cb_seg_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic        en,
  input  logic        shift,
  input  logic        din,
  output logic [23:0] rem
);
  logic [23:0] cur;
  logic        fb;

  // clr restarts from zero in the same cycle as the first bit of a block
  assign cur = clr ? '0 : rem;
  assign fb  = cur[23] ^ din;

  always_ff @(posedge clk) begin
    if (en)         rem <= {cur[22:0], 1'b0} ^ (fb ? CRC24B_POLY : '0);
    else if (shift) rem <= {cur[22:0], 1'b0};
    else if (clr)   rem <= '0;
  end
endmodule
`endif

// File: rtl/cb_seg_hs.sv
// Flow-controlled LTE code block segmenter: sizes C/K+/K-/C-/F, then streams filler, data and CB CRC.
// Optional CB_SEG_CRC24B_EN builds the CRC24B generator; otherwise CRC-phase bits are emitted as 0.
module cb_seg_hs
  import cb_seg_pkg::*;
#(
  parameter int Z      = Z_LTE,
  parameter int L_CRC  = L_CB,
  parameter int SIZE_W = 16,
  parameter int MAX_B  = 61440,
  parameter int CIDX_W = 4
) (
  input logic        clk,
  input logic        reset,
  cb_seg_hs_if.slave bus
);
  localparam logic [19:0] Z_W     = 20'(Z);
  localparam logic [19:0] ZL_STEP = 20'(Z - L_CRC);
  localparam logic [19:0] MAX_B_W = 20'(MAX_B);
  localparam logic [12:0] L_W     = 13'(L_CRC);

  seg_state_e state, state_nx;

  logic [19:0]       b_reg, acc, bp, ck, diff;
  logic [CIDX_W-1:0] c_cnt, c_m, r_idx;
  logic              multi, done_gen;
  logic [12:0]       k, kp, km, dk, f_len, pos;

  logic [19:0] b_in;
  logic        size_bad, size_acc, c_done, k_done, cm_done;
  logic [12:0] k_dn_step, kr, data_end, f_r;
  logic        ph_fill, ph_crc, ph_data, load_ok, gen, produce, last_bit, last_cb;
  logic        crc_bit;

  assign b_in      = 20'(bus.tb_size_in);
  assign size_bad  = (b_in == '0) || (b_in > MAX_B_W);
  assign size_acc  = (state == S_IDLE) && bus.wreq_size;
  assign c_done    = (b_reg <= Z_W) || (acc >= b_reg);
  assign k_done    = ck >= bp;
  assign cm_done   = !multi || (diff < 20'(dk));
  assign k_dn_step = 13'(k_step(k - 13'd1));

  assign kr       = (r_idx < c_m) ? km : kp;
  assign data_end = multi ? kr - L_W : kr;
  assign f_r      = (r_idx == '0) ? f_len : '0;
  assign ph_fill  = pos < f_r;
  assign ph_crc   = pos >= data_end;
  assign ph_data  = !ph_fill && !ph_crc;
  assign load_ok  = !bus.cb_valid || bus.cb_ready;
  assign gen      = (state == S_EMIT) && !done_gen && load_ok;
  assign produce  = gen && (!ph_data || bus.wreq_data);
  assign last_bit = pos == kr - 13'd1;
  assign last_cb  = r_idx == c_cnt - 1'b1;

  assign bus.data_ready = gen && ph_data;
  assign bus.size_ready = state == S_IDLE;

`ifdef CB_SEG_CRC24B_EN
  logic [23:0] crc_rem;

  crc24b_serial u_crc (
    .clk   (clk),
    .clr   (produce && (pos == '0)),
    .en    (produce && !ph_crc),
    .shift (produce && ph_crc),
    .din   (ph_data && bus.tb_in),
    .rem   (crc_rem)
  );
  assign crc_bit = crc_rem[23];
`else
  assign crc_bit = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (bus.wreq_size && !size_bad) state_nx = S_CALC_C;
      S_CALC_C:  if (c_done)                     state_nx = S_CALC_K;
      S_CALC_K:  if (k_done)                     state_nx = S_CALC_CM;
      S_CALC_CM: if (cm_done)                    state_nx = S_EMIT;
      S_EMIT:    if (done_gen && load_ok)        state_nx = S_IDLE;
      default:                                   state_nx = S_IDLE;
    endcase
  end

  // Control and output register: the only state touched by reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      bus.seg_err  <= 1'b0;
      bus.cb_valid <= 1'b0;
      bus.cb_data  <= 1'b0;
      bus.filling  <= 1'b0;
      bus.crc      <= 1'b0;
      bus.start    <= 1'b0;
      bus.stop     <= 1'b0;
      bus.cb_size  <= '0;
      bus.cb_idx   <= '0;
      pos          <= '0;
      r_idx        <= '0;
      done_gen     <= 1'b0;
    end else begin
      state       <= state_nx;
      bus.seg_err <= size_acc && size_bad;
      if (state == S_CALC_CM) begin
        pos      <= '0;
        r_idx    <= '0;
        done_gen <= 1'b0;
      end
      if ((state == S_EMIT) && load_ok) bus.cb_valid <= produce;
      if (produce) begin
        bus.cb_data <= ph_data ? bus.tb_in : (ph_crc && crc_bit);
        bus.filling <= ph_fill;
        bus.crc     <= ph_crc;
        bus.start   <= pos == '0;
        bus.stop    <= last_bit;
        bus.cb_size <= kr;
        bus.cb_idx  <= r_idx;
        if (last_bit) begin
          pos   <= '0;
          r_idx <= r_idx + 1'b1;
          if (last_cb) done_gen <= 1'b1;
        end else begin
          pos <= pos + 13'd1;
        end
      end
    end
  end

  // Segmentation arithmetic: every term is (re)loaded on entry to the state that uses it
  always_ff @(posedge clk) begin
    case (state)
      S_IDLE: if (bus.wreq_size) begin
        b_reg <= b_in;
        acc   <= '0;
        c_cnt <= '0;
      end
      S_CALC_C: begin
        if (b_reg <= Z_W) begin
          c_cnt <= CIDX_W'(1);
          multi <= 1'b0;
          bp    <= b_reg;
          ck    <= 20'(K_MIN);
          k     <= 13'(K_MIN);
        end else if (acc >= b_reg) begin
          multi <= 1'b1;
          bp    <= b_reg + 20'(c_cnt) * 20'(L_CRC);
          ck    <= 20'(c_cnt) * 20'(K_MIN);
          k     <= 13'(K_MIN);
        end else begin
          acc   <= acc + ZL_STEP;
          c_cnt <= c_cnt + 1'b1;
        end
      end
      S_CALC_K: begin
        if (k_done) begin
          kp   <= k;
          diff <= ck - bp;
          c_m  <= '0;
          dk   <= multi ? k_dn_step : '0;
          km   <= multi ? k - k_dn_step : '0;
        end else begin
          k  <= k + 13'(k_step(k));
          ck <= ck + 20'(c_cnt) * 20'(k_step(k));
        end
      end
      S_CALC_CM: begin
        // C*K+ - B' minus C- steps of (K+ - K-) leaves exactly the filler count F
        if (cm_done) f_len <= diff[12:0];
        else begin
          diff <= diff - 20'(dk);
          c_m  <= c_m + 1'b1;
        end
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_cb_seg_hs.sv
// Directed bench for cb_seg_hs: framing, CRC, backpressure, illegal sizes and mid-block reset.
module tb_cb_seg_hs;
  import cb_seg_pkg::*;

`ifdef CB_SEG_CRC24B_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif
  localparam int BUDGET = 40000;

  logic clk;
  logic reset;

  cb_seg_hs_if #(.SIZE_W(16), .CIDX_W(4)) bus ();

  cb_seg_hs dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;
  logic [21:0] q_beat[$];
  logic [21:0] e_beat[$];
  int n_consumed;
  int holds_bad;
  int lat;
  bit run_done;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit src_bit(input int i);
    int unsigned h;
    h = 32'(i) * 32'd2654435761;
    h = h ^ (h >> 15);
    return h[3];
  endfunction

  // Reference CRC24B by polynomial long division of msg * D^24; bit 23 is the first parity bit sent.
  function automatic logic [23:0] crc_ref(input bit msg[$]);
    bit          a[$];
    logic [24:0] g;
    logic [23:0] r;
    g = 25'h1800063;
    a = msg;
    for (int i = 0; i < 24; i++) a.push_back(1'b0);
    for (int i = 0; i < msg.size(); i++)
      if (a[i]) for (int j = 0; j < 25; j++) a[i+j] = a[i+j] ^ g[24-j];
    for (int k2 = 0; k2 < 24; k2++) r[23-k2] = a[msg.size()+k2];
    return r;
  endfunction

  // Expected beats {data, fill, crc, start, stop, size[12:0], idx[3:0]} from hand-computed C/K+/K-/C-/F.
  task automatic build_exp(input int c, input int kp, input int km, input int cm, input int f);
    int          l, kr, fr, src;
    bit          msg[$];
    logic [23:0] cr;
    bit          d, fl, cf;
    e_beat.delete();
    src = 0;
    cr  = '0;
    l   = (c > 1) ? 24 : 0;
    for (int r = 0; r < c; r++) begin
      kr = (r < cm) ? km : kp;
      fr = (r == 0) ? f : 0;
      msg.delete();
      for (int i = 0; i < kr; i++) begin
        if (i < fr) begin
          d = 1'b0; fl = 1'b1; cf = 1'b0;
          msg.push_back(1'b0);
        end else if (i < kr - l) begin
          d = src_bit(src); src++; fl = 1'b0; cf = 1'b0;
          msg.push_back(d);
        end else begin
          if (i == kr - l) cr = crc_ref(msg);
          d = CRC_ON ? cr[23-(i-(kr-l))] : 1'b0;
          fl = 1'b0; cf = 1'b1;
        end
        e_beat.push_back({d, fl, cf, (i == 0), (i == kr - 1), 13'(kr), 4'(r)});
      end
    end
  endtask

  task automatic run_seg(input int b, input bit stall, input int abort_at);
    int          cyc, didx;
    logic [22:0] snap, prev_snap;
    bit          prev_hold;
    q_beat.delete();
    run_done = 1'b0; holds_bad = 0; lat = -1; didx = 0; cyc = 0;
    prev_hold = 1'b0; prev_snap = '0;
    @(negedge clk);
    bus.tb_size_in = 16'(b);
    bus.wreq_size  = 1'b1;
    #1;
    chk("size_ready_at_req", bus.size_ready, 1);
    @(negedge clk);
    bus.wreq_size = 1'b0;
    while (cyc < BUDGET) begin
      cyc++;
      bus.cb_ready  = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.wreq_data = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.tb_in     = src_bit(didx);
      #1;
      snap = {bus.cb_valid, bus.cb_data, bus.filling, bus.crc, bus.start, bus.stop,
              bus.cb_size, bus.cb_idx};
      if (prev_hold && snap != prev_snap) holds_bad++;
      if (bus.cb_valid && lat < 0) lat = cyc;
      if (bus.data_ready && bus.wreq_data) didx++;
      if (bus.cb_valid && bus.cb_ready)
        q_beat.push_back({bus.cb_data, bus.filling, bus.crc, bus.start, bus.stop,
                          bus.cb_size, bus.cb_idx});
      prev_hold = bus.cb_valid && !bus.cb_ready;
      prev_snap = snap;
      if (bus.size_ready) begin
        run_done = 1'b1;
        break;
      end
      if (abort_at >= 0 && q_beat.size() >= abort_at) begin
        run_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_consumed = didx;
    bus.wreq_data = 1'b0;
  endtask

  task automatic check_stream(input string tag, input int b, input int lat_max);
    int bad, crc_bad, n;
    chk({tag, "_done"}, run_done, 1);
    chk({tag, "_len"}, q_beat.size(), e_beat.size());
    n = (q_beat.size() < e_beat.size()) ? q_beat.size() : e_beat.size();
    bad = 0; crc_bad = 0;
    for (int i = 0; i < n; i++) begin
      if (q_beat[i] != e_beat[i]) bad++;
      if (e_beat[i][19] && q_beat[i][21] != e_beat[i][21]) crc_bad++;
    end
    chk({tag, "_beats_bad"}, bad, 0);
    chk({tag, "_crc_bits_bad"}, crc_bad, 0);
    chk({tag, "_consumed"}, n_consumed, b);
    chk({tag, "_hold_bad"}, holds_bad, 0);
    chk({tag, "_lat_ok"}, (lat > 0 && lat <= lat_max), 1);
  endtask

  task automatic bad_size(input int b, input string tag);
    int n_err, n_vld, n_nrdy;
    @(negedge clk);
    bus.tb_size_in = 16'(b);
    bus.wreq_size  = 1'b1;
    #1;
    chk({tag, "_size_ready"}, bus.size_ready, 1);
    @(negedge clk);
    bus.wreq_size = 1'b0;
    n_err = 0; n_vld = 0; n_nrdy = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (bus.seg_err) n_err++;
      if (bus.cb_valid) n_vld++;
      if (!bus.size_ready) n_nrdy++;
      @(negedge clk);
    end
    chk({tag, "_err_cycles"}, n_err, 1);
    chk({tag, "_valid_cycles"}, n_vld, 0);
    chk({tag, "_not_ready_cycles"}, n_nrdy, 0);
  endtask

  task automatic check_idle_outs(input string tag);
    chk({tag, "_outs"}, {bus.cb_valid, bus.cb_data, bus.filling, bus.crc, bus.start, bus.stop,
                         bus.cb_size, bus.cb_idx, bus.seg_err, bus.data_ready}, 0);
    chk({tag, "_size_ready"}, bus.size_ready, 1);
  endtask

  initial begin
    reset          = 1'b0;
    bus.tb_size_in = '0;
    bus.wreq_size  = 1'b0;
    bus.tb_in      = 1'b0;
    bus.wreq_data  = 1'b0;
    bus.cb_ready   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check_idle_outs("reset");
    reset = 1'b1;

    // B=30: C=1, K+=40, F=10, table index 0
    build_exp(1, 40, 0, 0, 10);
    run_seg(30, 1'b0, -1);
    check_stream("b30", 30, 11);

    // B=6145: C=2, K+=3136, K-=3072, C-=1, F=15, K+ is table index 140
    build_exp(2, 3136, 3072, 1, 15);
    run_seg(6145, 1'b0, -1);
    check_stream("b6145", 6145, 153);

    // B=12240: C=2, K+=6144, C-=0, F=0, K+ is table index 187
    build_exp(2, 6144, 6080, 0, 0);
    run_seg(12240, 1'b0, -1);
    check_stream("b12240", 12240, 199);

    // Same B=6145 stream under random output stalls and input gaps
    build_exp(2, 3136, 3072, 1, 15);
    run_seg(6145, 1'b1, -1);
    check_stream("b6145_stall", 6145, 153);

    bad_size(0, "b0");
    bad_size(61441, "b61441");

    // Reset in the middle of CB1 of B=6145
    run_seg(6145, 1'b0, 3072 + 100);
    chk("mid_abort_done", run_done, 1);
    chk("mid_abort_in_cb1", (q_beat.size() > 0) ? int'(q_beat[q_beat.size()-1][3:0]) : -1, 1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_idle_outs("mid_reset");

    // B=40 after the reset: C=1, K+=40, F=0
    build_exp(1, 40, 0, 0, 0);
    run_seg(40, 1'b0, -1);
    check_stream("b40_after_reset", 40, 11);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
